power_state_ctrl: RTL and testbench
===================================

// Module: power_state_ctrl
// PURPOSE
// - Car power-state manager: owns the ON/OFF state of the vehicle logic.
// - Debounces the power button: long press powers on, short press powers off.
// - Drives `detect_start`, the start/enable of the downstream idle-timeout detector.
// - Consumes that detector's `idle_timeout` level to auto power-off.
// PARAMETERS
// - DEBOUNCE_CYCLES  default 20   consecutive stable cycles before btn_db follows the pin
// - HOLD_CYCLES      default 100  cycles btn_db must stay high in S_ARM to power on
// - Both parameters are >=2. Counter widths are $clog2(param)+1.
// PORTS
// - clk             in   1  system clock, all logic on posedge
// - rst_n           in   1  asynchronous, active-low reset
// - power_btn       in   1  raw push-button, async to clk, 1=pressed
// - idle_timeout    in   1  level from the idle detector, 1=no activity timeout reached
// - power_on        out  1  1 while state==S_ON (decoded from state register)
// - detect_start    out  1  equals power_on; enables downstream idle detector
// - power_on_pulse  out  1  one-cycle pulse on the first cycle of S_ON
// - off_cause       out  2  00 none/never off since on, 01 button, 10 idle timeout
// BEHAVIOUR
// - Reset (async, rst_n=0): state=S_OFF; btn_sync/btn_db/db_cnt/hold_cnt=0;
//   power_on=detect_start=power_on_pulse=0; off_cause=00. Reset mid-S_ON drops power at once.
// - Synchronizer: 2-flop chain power_btn->btn_sync.
// - Debounce counter db_cnt:
//   - If btn_sync==btn_db: db_cnt<=0.
//   - Else db_cnt increments.
//   - At db_cnt==DEBOUNCE_CYCLES-1 with mismatch still present: btn_db<=btn_sync, db_cnt<=0.
//   - Any glitch shorter than DEBOUNCE_CYCLES never reaches btn_db.
// - btn_rise = btn_db & ~btn_db_q (registered edge detect); one cycle per debounced press.
// - FSM (state register, 4 states):
//   - S_OFF: on btn_rise -> S_ARM, hold_cnt<=0. idle_timeout ignored.
//   - S_ARM: btn_db=0 -> S_OFF (short press, no power-on, off_cause unchanged).
//     Else hold_cnt++. At hold_cnt==HOLD_CYCLES-1 -> S_ON.
//     If btn_db goes high at edge k, state==S_ON from edge k+1+HOLD_CYCLES.
//   - S_ON: btn_rise -> S_OFF, off_cause<=01.
//     Else idle_timeout=1 -> S_OFF, off_cause<=10 (see CONFIGURATION).
//     Both in the same cycle: button wins, off_cause=01.
//     The held press that powered on never powers off; only a new rise does.
//   - S_OFF after S_ON: a held button does not re-arm; a fresh btn_rise is required.
// - Entering S_ON: off_cause<=00; power_on_pulse=1 for exactly that first S_ON cycle.
// - detect_start falls in the same cycle as power_on, so the idle detector clears its
//   count and its idle_timeout output.
// CONFIGURATION
// - POWER_AUTO_OFF_EN defined: idle_timeout causes S_ON->S_OFF as above.
// - POWER_AUTO_OFF_EN undefined: idle_timeout is unused; only a button press powers off;
//   off_cause never takes 10.
// TESTING  (DEBOUNCE_CYCLES=4, HOLD_CYCLES=10, POWER_AUTO_OFF_EN defined unless noted)
// - Reset then hold btn 30 cycles -> power_on=1 by edge ~17 from press;
//   one power_on_pulse; off_cause=00.
// - From S_OFF, press 8 cycles then release -> S_ARM then S_OFF; power_on stays 0.
// - In S_ON, release, wait 10, press 6 cycles -> power_on=0 within 8 cycles;
//   off_cause=01; the held button does not re-arm.
// - In S_ON, btn bounce 1-0-1-0 with 2-cycle pulses -> btn_db never toggles; power_on stays 1.
// - In S_ON, drive idle_timeout=1 -> power_on=0 next cycle, off_cause=10.
//   Repeat without macro -> power_on stays 1.
// - idle_timeout and btn_rise same cycle -> off_cause=01.
//   rst_n pulse mid-S_ARM -> all outputs 0, state S_OFF.

Source files
------------

// File: rtl/power_state_ctrl.sv
// -----------------------------------------------------------------------------
// power_state_ctrl
//   Car power-state manager. Owns the ON/OFF state of the vehicle logic:
//   a debounced long press of the power button powers on, a fresh press while
//   on powers off, and (optionally) the idle detector's timeout powers off.
//
//   Optional feature macro: POWER_AUTO_OFF_EN
//     defined   : idle_timeout=1 while on forces power-off (off_cause=10)
//     undefined : idle_timeout is ignored; only the button powers off
//
// Ports
//   clk            in   system clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   power_btn      in   raw push-button (asynchronous to clk), 1 = pressed
//   idle_timeout   in   idle detector timeout level, 1 = timeout reached
//   power_on       out  1 while the FSM is in S_ON
//   detect_start   out  enable for the downstream idle detector (= power_on)
//   power_on_pulse out  one-cycle pulse on the first cycle of S_ON
//   off_cause      out  00 none since power-on, 01 button, 10 idle timeout
// -----------------------------------------------------------------------------
module power_state_ctrl #(
  parameter int DEBOUNCE_CYCLES = 20,
  parameter int HOLD_CYCLES     = 100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       power_btn,
  input  logic       idle_timeout,
  output logic       power_on,
  output logic       detect_start,
  output logic       power_on_pulse,
  output logic [1:0] off_cause
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int HOLD_W = $clog2(HOLD_CYCLES) + 1;

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_BTN  = 2'b01;
  localparam logic [1:0] CAUSE_IDLE = 2'b10;

  // S_REL: powered off by the button, waiting for that press to be released.
  // It behaves like S_OFF from the outside but makes the "no re-arm while the
  // same press is held" rule explicit in the state machine.
  typedef enum logic [1:0] {
    S_OFF = 2'b00,
    S_ARM = 2'b01,
    S_ON  = 2'b10,
    S_REL = 2'b11
  } state_t;

  state_t              state_r, state_s;
  logic                btn_meta_r, btn_sync_r;
  logic                btn_db_r, btn_db_q_r;
  logic [DB_W-1:0]     db_cnt_r;
  logic [HOLD_W-1:0]   hold_cnt_r, hold_cnt_s;
  logic [1:0]          off_cause_r, off_cause_s;
  logic                power_on_pulse_r, power_on_pulse_s;
  logic                btn_rise_s;
  logic                idle_req_s;

  // Two-flop synchronizer for the asynchronous button pin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_meta_r <= 1'b0;
      btn_sync_r <= 1'b0;
    end else begin
      btn_meta_r <= power_btn;
      btn_sync_r <= btn_meta_r;
    end
  end

  // Debouncer: btn_db follows btn_sync only after DEBOUNCE_CYCLES of mismatch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_db_r   <= 1'b0;
      btn_db_q_r <= 1'b0;
      db_cnt_r   <= '0;
    end else begin
      btn_db_q_r <= btn_db_r;
      if (btn_sync_r == btn_db_r) begin
        db_cnt_r <= '0;
      end else if (db_cnt_r == DB_LAST) begin
        btn_db_r <= btn_sync_r;
        db_cnt_r <= '0;
      end else begin
        db_cnt_r <= db_cnt_r + DB_ONE;
      end
    end
  end

  assign btn_rise_s = btn_db_r & ~btn_db_q_r;

`ifdef POWER_AUTO_OFF_EN
  assign idle_req_s = idle_timeout;
`else
  // Auto power-off disabled: the input is referenced but masked off.
  assign idle_req_s = idle_timeout & 1'b0;
`endif

  // FSM next-state, hold counter, off-cause and power-on pulse decode.
  always_comb begin
    state_s          = state_r;
    hold_cnt_s       = hold_cnt_r;
    off_cause_s      = off_cause_r;
    power_on_pulse_s = 1'b0;
    case (state_r)
      S_OFF: begin
        if (btn_rise_s) begin
          state_s    = S_ARM;
          hold_cnt_s = '0;
        end else begin
          state_s = S_OFF;
        end
      end
      S_ARM: begin
        if (!btn_db_r) begin
          state_s = S_OFF;
        end else if (hold_cnt_r == HOLD_LAST) begin
          state_s     = S_ON;
          off_cause_s = CAUSE_NONE;
        end else begin
          hold_cnt_s = hold_cnt_r + HOLD_ONE;
        end
      end
      S_ON: begin
        // The press that powered on is already high, so only a new rise counts.
        if (btn_rise_s) begin
          state_s     = S_REL;
          off_cause_s = CAUSE_BTN;
        end else if (idle_req_s) begin
          state_s     = S_OFF;
          off_cause_s = CAUSE_IDLE;
        end else begin
          state_s = S_ON;
        end
      end
      S_REL: begin
        if (!btn_db_r) begin
          state_s = S_OFF;
        end else begin
          state_s = S_REL;
        end
      end
      default: begin
        state_s = S_OFF;
      end
    endcase
    if ((state_s == S_ON) && (state_r != S_ON)) begin
      power_on_pulse_s = 1'b1;
    end else begin
      power_on_pulse_s = 1'b0;
    end
  end

  // FSM state register and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r          <= S_OFF;
      hold_cnt_r       <= '0;
      off_cause_r      <= CAUSE_NONE;
      power_on_pulse_r <= 1'b0;
    end else begin
      state_r          <= state_s;
      hold_cnt_r       <= hold_cnt_s;
      off_cause_r      <= off_cause_s;
      power_on_pulse_r <= power_on_pulse_s;
    end
  end

  // Decoded from the state register so an async reset drops power at once.
  assign power_on       = (state_r == S_ON);
  assign detect_start   = power_on;
  assign power_on_pulse = power_on_pulse_r;
  assign off_cause      = off_cause_r;

endmodule

// File: tb/tb_power_state_ctrl.sv
// -----------------------------------------------------------------------------
// tb_power_state_ctrl
//   Directed bench for power_state_ctrl with DEBOUNCE_CYCLES=4, HOLD_CYCLES=10.
//   A table of input segments (button, idle level, cycle count) is applied in
//   order; after each segment power_on, detect_start, off_cause and the number
//   of power_on_pulse cycles seen are compared with hand-computed values.
//   Hand-written sequences cover button/idle collision and reset mid-arm.
// -----------------------------------------------------------------------------
module tb_power_state_ctrl;

`ifdef POWER_AUTO_OFF_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       power_btn;
  logic       idle_timeout;
  logic       power_on;
  logic       detect_start;
  logic       power_on_pulse;
  logic [1:0] off_cause;

  int checks;
  int failures;
  int pulse_cnt;

  power_state_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES    (10)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .power_btn     (power_btn),
    .idle_timeout  (idle_timeout),
    .power_on      (power_on),
    .detect_start  (detect_start),
    .power_on_pulse(power_on_pulse),
    .off_cause     (off_cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       btn;
    logic       idle;
    int         cycles;
    logic       exp_on;
    int         exp_pulses;
    logic [1:0] exp_cause;
  } vec_t;

  vec_t tbl [21];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Drive inputs for n cycles; outputs are sampled 1 time unit after each edge.
  task automatic step(input logic b, input logic i, input int n);
    for (int c = 0; c < n; c++) begin
      power_btn    = b;
      idle_timeout = i;
      @(posedge clk);
      #1;
      if (power_on_pulse) pulse_cnt++;
    end
  endtask

  task automatic chk_state(input string tag, input logic on, input int pulses,
                           input logic [1:0] cause);
    chk({tag, ".power_on"},     int'(power_on),     int'(on));
    chk({tag, ".detect_start"}, int'(detect_start), int'(on));
    chk({tag, ".pulses"},       pulse_cnt,          pulses);
    chk({tag, ".off_cause"},    int'(off_cause),    int'(cause));
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    pulse_cnt = 0;
    rst_n        = 1'b0;
    power_btn    = 1'b0;
    idle_timeout = 1'b0;

    // Press is first sampled at segment edge 1; btn_db rises at edge 6;
    // S_ARM from edge 7; S_ON from edge 17.
    tbl[0]  = '{1'b0, 1'b0,  5, 1'b0, 0, 2'b00};
    tbl[1]  = '{1'b1, 1'b0, 16, 1'b0, 0, 2'b00};  // one edge short of power-on
    tbl[2]  = '{1'b1, 1'b0,  1, 1'b1, 1, 2'b00};  // edge 17: S_ON
    tbl[3]  = '{1'b1, 1'b0, 15, 1'b1, 0, 2'b00};  // held press never powers off
    tbl[4]  = '{1'b0, 1'b0, 12, 1'b1, 0, 2'b00};
    tbl[5]  = '{1'b1, 1'b0,  6, 1'b1, 0, 2'b00};  // rise present after edge 6
    tbl[6]  = '{1'b1, 1'b0,  1, 1'b0, 0, 2'b01};  // off at edge 7
    tbl[7]  = '{1'b1, 1'b0, 30, 1'b0, 0, 2'b01};  // held button does not re-arm
    tbl[8]  = '{1'b0, 1'b0, 10, 1'b0, 0, 2'b01};
    tbl[9]  = '{1'b1, 1'b0,  8, 1'b0, 0, 2'b01};  // short press: S_ARM
    tbl[10] = '{1'b0, 1'b0, 12, 1'b0, 0, 2'b01};  // back to S_OFF, cause kept
    tbl[11] = '{1'b0, 1'b1,  5, 1'b0, 0, 2'b01};  // idle ignored while off
    tbl[12] = '{1'b1, 1'b0, 16, 1'b0, 0, 2'b01};
    tbl[13] = '{1'b1, 1'b0,  1, 1'b1, 1, 2'b00};  // on again, cause cleared
    tbl[14] = '{1'b0, 1'b0, 12, 1'b1, 0, 2'b00};
    tbl[15] = '{1'b1, 1'b0,  2, 1'b1, 0, 2'b00};  // bounce 1-0-1-0, 2 cycles each
    tbl[16] = '{1'b0, 1'b0,  2, 1'b1, 0, 2'b00};
    tbl[17] = '{1'b1, 1'b0,  2, 1'b1, 0, 2'b00};
    tbl[18] = '{1'b0, 1'b0,  6, 1'b1, 0, 2'b00};
    tbl[19] = '{1'b0, 1'b1,  1, logic'(!AUTO), 0, (AUTO ? 2'b10 : 2'b00)};
    tbl[20] = '{1'b0, 1'b0,  3, logic'(!AUTO), 0, (AUTO ? 2'b10 : 2'b00)};

    // Reset state, before any clock edge.
    #3;
    chk_state("reset", 1'b0, 0, 2'b00);
    chk("reset.pulse_level", int'(power_on_pulse), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int v = 0; v < 21; v++) begin
      pulse_cnt = 0;
      step(tbl[v].btn, tbl[v].idle, tbl[v].cycles);
      chk_state($sformatf("vec%0d", v), tbl[v].exp_on, tbl[v].exp_pulses,
                tbl[v].exp_cause);
    end

    // Button rise and idle timeout in the same cycle: button wins.
    pulse_cnt = 0;
    if (AUTO) begin
      step(1'b1, 1'b0, 17);
      step(1'b0, 1'b0, 12);
      chk_state("collide.on", 1'b1, 1, 2'b00);
    end else begin
      chk_state("collide.on", 1'b1, 0, 2'b00);
    end
    pulse_cnt = 0;
    step(1'b1, 1'b0, 6);
    chk_state("collide.pre", 1'b1, 0, 2'b00);
    step(1'b1, 1'b1, 1);
    chk_state("collide.off", 1'b0, 0, 2'b01);

    // Asynchronous reset in the middle of S_ARM.
    step(1'b0, 1'b0, 12);
    step(1'b1, 1'b0, 8);
    chk_state("arm.pre", 1'b0, 0, 2'b01);
    power_btn = 1'b0;
    rst_n     = 1'b0;
    #2;
    chk_state("arm.reset", 1'b0, 0, 2'b00);
    chk("arm.reset.pulse_level", int'(power_on_pulse), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // From reset a full long press must be needed again.
    pulse_cnt = 0;
    step(1'b0, 1'b0, 4);
    step(1'b1, 1'b0, 16);
    chk_state("rearm.pre", 1'b0, 0, 2'b00);
    step(1'b1, 1'b0, 1);
    chk_state("rearm.on", 1'b1, 1, 2'b00);
    step(1'b1, 1'b0, 1);
    chk("rearm.pulse_width", int'(power_on_pulse), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
